spi_slave: RTL and testbench



---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_slave_if.sv | 43 ++++
 rtl/spi_tx_shifter.sv | 42 ++++
 rtl/spi_slave.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave front end.
//   spi_state_t - top-level FSM states
//   rd_phase_t  - sub-phases of a read-data transaction
//   CMD_*       - two-bit command codes carried in frame bits [9:8]
//   FRAME_W     - frame width for the default RAM word size
//   frame_width - frame width for an arbitrary RAM word size
package spi_pkg;

  localparam int DEFAULT_ADDR_SIZE = 8;
  localparam int FRAME_W           = DEFAULT_ADDR_SIZE + 2;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_t;

  // A read-data frame first receives its frame, then waits for the RAM,
  // then serializes the reply, then idles with MISO low until SS_n rises.
  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT,
    PH_TX,
    PH_DONE
  } rd_phase_t;

  // Frame = two command bits followed by an address/data word.
  function automatic int frame_width(input int addr_size);
    return addr_size + 2;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: serial pins and RAM-side handshake of the SPI slave.
//   SS_n     - slave select, active low (master -> slave)
//   MOSI     - serial data in, MSB first (master -> slave)
//   MISO     - serial reply, MSB first (slave -> master)
//   rx_data  - received frame, bits [9:8] command (slave -> RAM)
//   rx_valid - one-cycle strobe qualifying rx_data (slave -> RAM)
//   tx_data  - read data from the RAM (RAM -> slave)
//   tx_valid - tx_data valid level, may stay high (RAM -> slave)
// The slave modport is the DUT view; master is the view of whoever
// drives the serial side and plays the RAM.
interface spi_slave_if #(
  parameter int ADDR_SIZE = 8
);

  logic                   SS_n;
  logic                   MOSI;
  logic                   MISO;
  logic [ADDR_SIZE+1:0]   rx_data;
  logic                   rx_valid;
  logic [ADDR_SIZE-1:0]   tx_data;
  logic                   tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    input  tx_data,
    input  tx_valid,
    output MISO,
    output rx_data,
    output rx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    output tx_data,
    output tx_valid,
    input  MISO,
    input  rx_data,
    input  rx_valid
  );

endinterface

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: parallel-load, MSB-first serializer for the read reply.
//   clk      - clock, all logic on posedge
//   rst_n    - synchronous active-low reset
//   load     - capture data; its MSB appears on MISO the next cycle
//   shift_en - advance to the next bit; zeros shift in behind the word
//   clear    - force the register and MISO to zero (wins over load/shift)
//   data     - parallel word to serialize
//   MISO     - registered serial output
module spi_tx_shifter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic                 clear,
  input  logic [ADDR_SIZE-1:0] data,
  output logic                 MISO
);

  logic [ADDR_SIZE-1:0] shreg;
  logic                 miso_q;

  // MISO is registered so it never glitches. On load the MSB goes straight
  // into the output flop and the remaining bits wait in shreg; because
  // zeros fill from the bottom, the shift after the last bit drops MISO to 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shreg  <= '0;
      miso_q <= 1'b0;
    end else if (load) begin
      miso_q <= data[ADDR_SIZE-1];
      shreg  <= {data[ADDR_SIZE-2:0], 1'b0};
    end else if (shift_en) begin
      miso_q <= shreg[ADDR_SIZE-1];
      shreg  <= {shreg[ADDR_SIZE-2:0], 1'b0};
    end
  end

  assign MISO = miso_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: serial front end of the SPI memory subsystem.
// Deserializes MOSI frames of ADDR_SIZE+2 bits into rx_data with a
// one-cycle rx_valid strobe. For read-data commands, the RAM reply on
// tx_data/tx_valid is captured and shifted out MSB-first on MISO.
//   clk   - single clock; SPI bits are sampled on its posedge
//   rst_n - synchronous active-low reset
//   bus   - spi_slave_if slave modport (SS_n, MOSI, MISO, rx_*, tx_*)
module spi_slave
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input logic        clk,
  input logic        rst_n,
  spi_slave_if.slave bus
);

  localparam int FW    = frame_width(ADDR_SIZE);
  localparam int CNT_W = $clog2(FW + 1);

  // Counter values: bit_cnt counts frame bits already shifted in, then is
  // reused to count reply bits during the TX phase.
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_RX_BIT = CNT_W'(FW - 1);
  localparam logic [CNT_W-1:0] RX_DONE     = CNT_W'(FW);
  localparam logic [CNT_W-1:0] LAST_TX_BIT = CNT_W'(ADDR_SIZE - 1);

  spi_state_t       state,        state_nxt;
  rd_phase_t        phase,        phase_nxt;
  logic [CNT_W-1:0] bit_cnt,      bit_cnt_nxt;
  logic [FW-2:0]    rx_shift,     rx_shift_nxt;
  logic [FW-1:0]    rx_data_q,    rx_data_nxt;
  logic             rx_valid_q,   rx_valid_nxt;
  logic             rd_addr_done, rd_addr_done_nxt;

  logic             tx_load;
  logic             tx_shift;
  logic             tx_clear;

  // Frame as it would look if the bit on MOSI right now were the last one.
  // rx_shift only needs FW-1 bits because the final bit goes directly into
  // rx_data without passing through the shift register.
  logic [FW-1:0]    rx_frame;
  logic             rx_last;

  assign rx_frame = {rx_shift, bus.MOSI};
  assign rx_last  = (bit_cnt == LAST_RX_BIT);

  // State register. Reset wins over everything, including a frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= PH_RX;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      bit_cnt      <= bit_cnt_nxt;
      rx_shift     <= rx_shift_nxt;
      rx_data_q    <= rx_data_nxt;
      rx_valid_q   <= rx_valid_nxt;
      rd_addr_done <= rd_addr_done_nxt;
    end
  end

  // Next-state and control decode. MISO is kept cleared except while a
  // reply is being loaded or shifted, so every other path leaves it at 0.
  // Deselect in any active state drops the frame without touching rx_data
  // or rd_addr_done.
  always_comb begin
    state_nxt        = state;
    phase_nxt        = phase;
    bit_cnt_nxt      = bit_cnt;
    rx_shift_nxt     = rx_shift;
    rx_data_nxt      = rx_data_q;
    rx_valid_nxt     = 1'b0;
    rd_addr_done_nxt = rd_addr_done;
    tx_load          = 1'b0;
    tx_shift         = 1'b0;
    tx_clear         = 1'b1;

    if (state != IDLE && bus.SS_n) begin
      state_nxt   = IDLE;
      phase_nxt   = PH_RX;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt_nxt  = '0;
          rx_shift_nxt = '0;
          phase_nxt    = PH_RX;
          if (!bus.SS_n) begin
            state_nxt = CHK_CMD;
          end
        end

        // Only the first command bit steers the FSM; the second one is
        // simply carried along in rx_data for the RAM to decode.
        CHK_CMD: begin
          rx_shift_nxt = rx_frame[FW-2:0];
          bit_cnt_nxt  = CNT_ONE;
          phase_nxt    = PH_RX;
          if (!bus.MOSI) begin
            state_nxt = WRITE;
          end else if (!rd_addr_done) begin
            state_nxt = READ_ADD;
          end else begin
            state_nxt = READ_DATA;
          end
        end

        // Once the frame is complete bit_cnt parks at RX_DONE, so extra
        // MOSI bits are ignored until the master deselects.
        WRITE, READ_ADD: begin
          if (bit_cnt != RX_DONE) begin
            rx_shift_nxt = rx_frame[FW-2:0];
            bit_cnt_nxt  = bit_cnt + CNT_ONE;
            if (rx_last) begin
              rx_valid_nxt = 1'b1;
              rx_data_nxt  = rx_frame;
              if (state == READ_ADD) begin
                rd_addr_done_nxt = 1'b1;
              end
            end
          end
        end

        READ_DATA: begin
          case (phase)
            PH_RX: begin
              rx_shift_nxt = rx_frame[FW-2:0];
              bit_cnt_nxt  = bit_cnt + CNT_ONE;
              if (rx_last) begin
                rx_valid_nxt     = 1'b1;
                rx_data_nxt      = rx_frame;
                rd_addr_done_nxt = 1'b0;
                phase_nxt        = PH_WAIT;
              end
            end

            // tx_valid may still be high from an earlier read, so the cycle
            // in which rx_valid is out is never a capture cycle; the RAM has
            // not seen this request yet.
            PH_WAIT: begin
              if (!rx_valid_q && bus.tx_valid) begin
                tx_load     = 1'b1;
                tx_clear    = 1'b0;
                bit_cnt_nxt = '0;
                phase_nxt   = PH_TX;
              end
            end

            // One shift per cycle; the shift after the LSB empties MISO.
            PH_TX: begin
              tx_shift    = 1'b1;
              tx_clear    = 1'b0;
              bit_cnt_nxt = bit_cnt + CNT_ONE;
              if (bit_cnt == LAST_TX_BIT) begin
                phase_nxt = PH_DONE;
              end
            end

            PH_DONE: begin
              phase_nxt = PH_DONE;
            end

            default: begin
              phase_nxt = PH_DONE;
            end
          endcase
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  spi_tx_shifter #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_tx_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .shift_en (tx_shift),
    .clear    (tx_clear),
    .data     (bus.tx_data),
    .MISO     (bus.MISO)
  );

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: self-checking bench for spi_slave.
// Each frame is driven cycle by cycle; expected rx_valid/rx_data/MISO are
// worked out from the frame's command bit, a model of the read-address
// flag, and the cycle at which the bench's RAM raises tx_valid.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int AW = DEFAULT_ADDR_SIZE;
  localparam int FW = FRAME_W;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Reference model state: last completed frame and read-address flag.
  logic          ref_flag;
  logic [FW-1:0] last_rx;

  spi_slave_if #(.ADDR_SIZE(AW)) bus ();

  spi_slave #(.ADDR_SIZE(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one frame starting in IDLE. abort_at: cycle at which SS_n rises
  // early (0 = never). tx_delay: extra cycles before the RAM raises
  // tx_valid. tx_hold: tx_valid held high throughout. rst_at: cycle with
  // rst_n low (0 = none). Cycle 0 presents SS_n=0, cycles 1..FW the bits.
  task automatic applyStimulus(input logic [FW-1:0] frame, input int abort_at,
                               input int tx_delay, input bit tx_hold,
                               input logic [AW-1:0] tx_word, input int rst_at);
    bit            completes;
    bit            rd_data;
    bit            flag_after;
    int            cap;
    int            body_end;
    logic          miso_exp;
    logic          rxv_exp;
    logic [FW-1:0] rxd_exp;

    completes  = (abort_at == 0);
    rd_data    = frame[FW-1] && ref_flag;
    flag_after = rd_data ? 1'b0 : (frame[FW-1] ? 1'b1 : ref_flag);
    cap        = tx_hold ? FW + 2 : FW + 2 + tx_delay;
    body_end   = !completes ? abort_at : (rd_data ? cap + AW + 2 : FW + 3);

    for (int t = 0; t <= body_end + 1; t++) begin
      rst_n         = !(rst_at != 0 && t == rst_at);
      bus.SS_n      = (t >= body_end) || (rst_at != 0 && t > rst_at);
      bus.MOSI      = (t >= 1 && t <= FW) ? frame[FW - t] : 1'($urandom);
      bus.tx_valid  = tx_hold || (rd_data && t >= cap);
      bus.tx_data   = tx_word;
      @(negedge clk);

      if (rst_at != 0 && t == rst_at + 1) begin
        checkOutput("rst_MISO", 32'(bus.MISO), 32'd0);
        checkOutput("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        checkOutput("rst_rx_data", 32'(bus.rx_data), 32'd0);
        checkOutput("rst_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        ref_flag = 1'b0;
        last_rx  = '0;
        @(posedge clk);
        #1;
        return;
      end

      rxv_exp  = completes && (t == FW + 1);
      rxd_exp  = (completes && t >= FW + 1) ? frame : last_rx;
      miso_exp = (completes && rd_data && t >= cap + 1 && t <= cap + AW) ?
                 tx_word[AW - 1 - (t - cap - 1)] : 1'b0;
      checkOutput($sformatf("rx_valid@t%0d", t), 32'(bus.rx_valid), 32'(rxv_exp));
      checkOutput($sformatf("rx_data@t%0d", t), 32'(bus.rx_data), 32'(rxd_exp));
      checkOutput($sformatf("MISO@t%0d", t), 32'(bus.MISO), 32'(miso_exp));

      if (t == body_end + 1) begin
        checkOutput("state_idle", 32'(dut.state), 32'(IDLE));
        checkOutput("rd_addr_done", 32'(dut.rd_addr_done),
                    32'(completes ? flag_after : ref_flag));
      end

      @(posedge clk);
      #1;
    end

    if (completes) begin
      last_rx  = frame;
      ref_flag = flag_after;
    end
  endtask

  initial begin
    logic [1:0] cmd;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b0;
    bus.MOSI     = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = '1;
    ref_flag     = 1'b0;
    last_rx      = '0;

    // Reset with the bus busy: everything must come up idle and zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_MISO", 32'(bus.MISO), 32'd0);
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'd0);
    checkOutput("reset_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
    checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.SS_n     = 1'b1;
    bus.tx_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] write-address frame");
    applyStimulus({CMD_WR_ADDR, 8'h05}, 0, 0, 1'b0, 8'h00, 0);

    $display("[TB] write-data frame with tx_valid stuck high");
    applyStimulus({CMD_WR_DATA, 8'hA5}, 0, 0, 1'b1, 8'h3C, 0);

    $display("[TB] read-address then read-data frame");
    applyStimulus({CMD_RD_ADDR, 8'h05}, 0, 0, 1'b0, 8'h00, 0);
    applyStimulus({CMD_RD_DATA, 8'h00}, 0, 0, 1'b0, 8'hA5, 0);

    $display("[TB] read-data command with no prior read-address");
    applyStimulus({CMD_RD_DATA, 8'hC4}, 0, 0, 1'b0, 8'h77, 0);
    applyStimulus({CMD_RD_DATA, 8'h11}, 0, 3, 1'b0, 8'h96, 0);

    $display("[TB] read-data with tx_valid already high");
    applyStimulus({CMD_RD_ADDR, 8'h42}, 0, 0, 1'b1, 8'h5A, 0);
    applyStimulus({CMD_RD_DATA, 8'h42}, 0, 0, 1'b1, 8'hC3, 0);

    $display("[TB] deselect after four bits, then a full frame");
    applyStimulus({CMD_WR_ADDR, 8'hF0}, 5, 0, 1'b0, 8'h00, 0);
    applyStimulus({CMD_WR_DATA, 8'hAA}, 0, 0, 1'b0, 8'h00, 0);

    $display("[TB] randomized frames");
    for (int i = 0; i < 16; i++) begin
      cmd = 2'($urandom_range(0, 3));
      applyStimulus({cmd, 8'($urandom)},
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FW)) : 0,
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    8'($urandom), 0);
    end

    $display("[TB] reset while MISO carries bit 3");
    if (!ref_flag) begin
      applyStimulus({CMD_RD_ADDR, 8'h33}, 0, 0, 1'b0, 8'h00, 0);
    end
    applyStimulus({CMD_RD_DATA, 8'h33}, 0, 0, 1'b0, 8'hE7, FW + 7);

    $display("[TB] frame after mid-transfer reset");
    applyStimulus({CMD_RD_ADDR, 8'h81}, 0, 0, 1'b0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
